darkroom_spi_receiver: RTL

//  SPI slave receiving the 256-bit DarkRoom sensor frames: 8 x 32-bit decoded lighthouse words per frame.

---
 rtl/darkroom_spi_receiver.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/darkroom_spi_receiver.sv
// Mode-0 SPI slave for DarkRoom sensor frames: deserialises, length-checks and commits whole frames,
// exposed on an Avalon-MM read slave. Define DARKROOM_RX_TIMESTAMP_EN to add a commit timestamp register.
`timescale 1ns/1ps
module darkroom_spi_receiver #(
    parameter int WORDS_PER_FRAME = 8,
    parameter int SYNC_STAGES     = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sck_i,
    input  logic        ss_n_i,
    input  logic        mosi_i,
    input  logic [6:0]  address,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        frame_valid_o,
    output logic        frame_error_o
);

    localparam int FRAME_BITS = 32 * WORDS_PER_FRAME;
    localparam int BC_W       = $clog2(FRAME_BITS + 1);
    localparam int WI_W       = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;

    localparam logic [BC_W-1:0] BC_FULL     = BC_W'(FRAME_BITS);
    localparam logic [6:0]      ADDR_COUNTS = 7'(WORDS_PER_FRAME);
    localparam logic [6:0]      ADDR_STATUS = 7'(WORDS_PER_FRAME + 1);
`ifdef DARKROOM_RX_TIMESTAMP_EN
    localparam logic [6:0]      ADDR_TS     = 7'(WORDS_PER_FRAME + 2);
`endif

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync_p0;
    logic [SYNC_STAGES-1:0] ss_n_sync_p0;
    logic [SYNC_STAGES-1:0] mosi_sync_p0;
    logic                   sck_p1;
    logic                   ss_n_p1;

    logic sck_s;
    logic ss_n_s;
    logic mosi_s;
    logic sck_rise;
    logic ss_fall;
    logic ss_rise;

    logic [0:0]            state;
    logic [BC_W-1:0]       bit_count;
    logic [BC_W-4:0]       byte_idx;
    logic [6:0]            byte_sr;
    logic [FRAME_BITS-1:0] shift_frame;
    logic [FRAME_BITS-1:0] committed;
    logic [FRAME_BITS-1:0] shadow;
    logic [FRAME_BITS-1:0] snap_frame;
    logic                  overflow;
    logic                  overflow_sticky;
    logic [15:0]           frame_count;
    logic [15:0]           error_count;

    logic                  commit_now;
    logic                  discard_now;
    logic                  overflow_hit;
    logic                  rd_accept;
    logic [WI_W-1:0]       word_idx;
    logic [31:0]           rd_word;

    // ---- stage p0/p1: input synchronisers and edge history ----
    // ss_n history resets low so a select already held low at reset release never looks like a falling edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_p0  <= '0;
            ss_n_sync_p0 <= '0;
            mosi_sync_p0 <= '0;
            sck_p1       <= 1'b0;
            ss_n_p1      <= 1'b0;
        end else begin
            sck_sync_p0  <= {sck_sync_p0[SYNC_STAGES-2:0], sck_i};
            ss_n_sync_p0 <= {ss_n_sync_p0[SYNC_STAGES-2:0], ss_n_i};
            mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], mosi_i};
            sck_p1       <= sck_sync_p0[SYNC_STAGES-1];
            ss_n_p1      <= ss_n_sync_p0[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync_p0[SYNC_STAGES-1];
    assign ss_n_s   = ss_n_sync_p0[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_p0[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_p1;
    assign ss_fall  = ss_n_p1 & ~ss_n_s;
    assign ss_rise  = ~ss_n_p1 & ss_n_s;

    assign byte_idx     = bit_count[BC_W-1:3];
    assign commit_now   = (state == ST_RECV) && ss_rise && (bit_count == BC_FULL) && !overflow;
    assign discard_now  = (state == ST_RECV) && ss_rise && !((bit_count == BC_FULL) && !overflow);
    assign overflow_hit = (state == ST_RECV) && !ss_rise && sck_rise && (bit_count == BC_FULL);
    assign snap_frame   = commit_now ? shift_frame : committed;

    // ---- stage p2: frame receive FSM and commit ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            bit_count     <= '0;
            byte_sr       <= '0;
            shift_frame   <= '0;
            committed     <= '0;
            overflow      <= 1'b0;
            frame_count   <= '0;
            error_count   <= '0;
            frame_valid_o <= 1'b0;
            frame_error_o <= 1'b0;
        end else begin
            frame_valid_o <= commit_now;
            frame_error_o <= discard_now;
            if (commit_now) begin
                committed   <= shift_frame;
                frame_count <= frame_count + 16'd1;
            end
            if (discard_now) begin
                error_count <= error_count + 16'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state       <= ST_RECV;
                        bit_count   <= '0;
                        byte_sr     <= '0;
                        shift_frame <= '0;
                        overflow    <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (ss_rise) begin
                        state <= ST_IDLE;
                    end else if (sck_rise) begin
                        if (bit_count == BC_FULL) begin
                            overflow <= 1'b1;
                        end else begin
                            byte_sr   <= {byte_sr[5:0], mosi_s};
                            bit_count <= bit_count + 1'b1;
                            if (bit_count[2:0] == 3'd7) begin
                                shift_frame[{byte_idx, 3'b000} +: 8] <= {byte_sr, mosi_s};
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DARKROOM_RX_TIMESTAMP_EN
    logic [31:0] cycle_cnt;
    logic [31:0] commit_ts;
    logic [31:0] shadow_ts;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
            commit_ts <= '0;
            shadow_ts <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (commit_now) begin
                commit_ts <= cycle_cnt;
            end
            if (rd_accept && (address == 7'd0)) begin
                shadow_ts <= commit_now ? cycle_cnt : commit_ts;
            end
        end
    end
`endif

    assign rd_accept = read && !waitrequest;
    assign word_idx  = address[WI_W-1:0];

    // Word 0 comes from the same snapshot that refreshes the shadow, keeping 0..N-1 coherent.
    always_comb begin
        rd_word = '0;
        if (address == 7'd0) begin
            rd_word = snap_frame[31:0];
        end else if (address < ADDR_COUNTS) begin
            rd_word = shadow[{word_idx, 5'b00000} +: 32];
        end else if (address == ADDR_COUNTS) begin
            rd_word = {error_count, frame_count};
        end else if (address == ADDR_STATUS) begin
            rd_word = {30'b0, overflow_sticky, (state == ST_RECV)};
`ifdef DARKROOM_RX_TIMESTAMP_EN
        end else if (address == ADDR_TS) begin
            rd_word = shadow_ts;
`endif
        end
    end

    // ---- stage p3: Avalon read response, one wait cycle per accepted read ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata        <= '0;
            waitrequest     <= 1'b0;
            shadow          <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            waitrequest <= rd_accept;
            if (rd_accept) begin
                readdata <= rd_word;
                if (address == 7'd0) begin
                    shadow <= snap_frame;
                end
            end
            if (overflow_hit) begin
                overflow_sticky <= 1'b1;
            end else if (rd_accept && (address == ADDR_STATUS)) begin
                overflow_sticky <= 1'b0;
            end
        end
    end

endmodule
